code_auth_fsm: RTL and testbench



---
 rtl/auth_pkg.sv | 16 +
 rtl/auth_compare.sv | 30 +++
 rtl/code_auth_fsm.sv | 147 ++++++++++++++
 tb/tb_code_auth_fsm.sv | 132 +++++++++++++
 4 files changed

// File: rtl/auth_pkg.sv
// Shared definitions for the code authenticator: state encoding and the
// default parameter values used by code_auth_fsm.
package auth_pkg;

   // Two-bit state encoding of the authenticator
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_LOCKED = 2'd2
   } auth_state_t;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_MAX_TRIES   = 3;
   localparam int DEF_LOCK_CYCLES = 16;

endpackage : auth_pkg

// File: rtl/auth_compare.sv
// Combinational WIDTH-bit equality: AND-reduce of the per-bit XNOR of
// secret and guess. When AUTH_DIFF_EN is defined it also exposes the
// per-bit XOR (difference) vector.
module auth_compare #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] secret,
   input  logic [WIDTH-1:0] guess,
`ifdef AUTH_DIFF_EN
   output logic [WIDTH-1:0] diff,
`endif
   output logic             equal
);

   logic [WIDTH-1:0] xnor_vec;

   // One XNOR per bit; a bit is 1 where secret and guess agree
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign xnor_vec[gi] = ~(secret[gi] ^ guess[gi]);
      end
   endgenerate

   assign equal = &xnor_vec;

`ifdef AUTH_DIFF_EN
   assign diff = ~xnor_vec;
`endif

endmodule : auth_compare

// File: rtl/code_auth_fsm.sv
// Sequential code authenticator. Holds a secret loaded by the setter,
// checks guesses against it, counts consecutive failures and enters a
// timed lockout after MAX_TRIES of them. All outputs are registered.
// Optional macro AUTH_DIFF_EN adds the diff_bits output (secret XOR guess).
module code_auth_fsm
   import auth_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int MAX_TRIES   = DEF_MAX_TRIES,
   parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           set_valid,
   input  logic [WIDTH-1:0]               set_code,
   input  logic                           guess_valid,
   input  logic [WIDTH-1:0]               guess_code,
   output logic                           matched,
   output logic                           unmatched,
   output logic                           rejected,
   output logic                           locked,
   output logic                           armed,
`ifdef AUTH_DIFF_EN
   output logic [WIDTH-1:0]               diff_bits,
`endif
   output logic [$clog2(MAX_TRIES+1)-1:0] tries_left
);

   localparam int TW = $clog2(MAX_TRIES + 1);
   localparam int LW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

   localparam logic [TW-1:0] TRIES_FULL = TW'(MAX_TRIES);
   localparam logic [LW-1:0] LOCK_LOAD  = LW'(LOCK_CYCLES - 1);

   auth_state_t      state_reg;
   logic [WIDTH-1:0] secret_reg;
   logic [LW-1:0]    lock_cnt_reg;
   logic             equal;
`ifdef AUTH_DIFF_EN
   logic [WIDTH-1:0] diff_vec;
`endif

   auth_compare #(
      .WIDTH (WIDTH)
   ) u_compare (
      .secret (secret_reg),
      .guess  (guess_code),
`ifdef AUTH_DIFF_EN
      .diff   (diff_vec),
`endif
      .equal  (equal)
   );

   // State machine with registered pulses, status flags and counters
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         secret_reg   <= '0;
         lock_cnt_reg <= '0;
         matched      <= 1'b0;
         unmatched    <= 1'b0;
         rejected     <= 1'b0;
         locked       <= 1'b0;
         armed        <= 1'b0;
         tries_left   <= TRIES_FULL;
`ifdef AUTH_DIFF_EN
         diff_bits    <= '0;
`endif
      end else begin
         // Pulses default low so each lasts exactly one cycle
         matched   <= 1'b0;
         unmatched <= 1'b0;
         rejected  <= 1'b0;

         case (state_reg)
            ST_IDLE: begin
               // No secret yet: every guess is turned away
               if (guess_valid) begin
                  rejected <= 1'b1;
               end
               if (set_valid) begin
                  secret_reg <= set_code;
                  state_reg  <= ST_ARMED;
                  armed      <= 1'b1;
                  tries_left <= TRIES_FULL;
               end
            end

            ST_ARMED: begin
               if (set_valid) begin
                  // A new secret wins over a same-cycle guess
                  secret_reg <= set_code;
                  tries_left <= TRIES_FULL;
                  if (guess_valid) begin
                     rejected <= 1'b1;
                  end
               end else if (guess_valid) begin
                  if (equal) begin
                     matched    <= 1'b1;
                     tries_left <= TRIES_FULL;
`ifdef AUTH_DIFF_EN
                     diff_bits  <= '0;
`endif
                  end else begin
                     unmatched <= 1'b1;
`ifdef AUTH_DIFF_EN
                     diff_bits <= diff_vec;
`endif
                     if (tries_left <= TW'(1)) begin
                        // Last allowed failure: start the lockout timer
                        tries_left   <= '0;
                        state_reg    <= ST_LOCKED;
                        locked       <= 1'b1;
                        armed        <= 1'b0;
                        lock_cnt_reg <= LOCK_LOAD;
                     end else begin
                        tries_left <= tries_left - TW'(1);
                     end
                  end
               end
            end

            ST_LOCKED: begin
               // Guesses are refused and secret updates are dropped
               if (guess_valid) begin
                  rejected <= 1'b1;
               end
               if (lock_cnt_reg == '0) begin
                  state_reg  <= ST_ARMED;
                  locked     <= 1'b0;
                  armed      <= 1'b1;
                  tries_left <= TRIES_FULL;
               end else begin
                  lock_cnt_reg <= lock_cnt_reg - LW'(1);
               end
            end

            default: begin
               state_reg <= ST_IDLE;
               locked    <= 1'b0;
               armed     <= 1'b0;
            end
         endcase
      end
   end

endmodule : code_auth_fsm

// File: tb/tb_code_auth_fsm.sv
// Directed bench for code_auth_fsm (WIDTH=8, MAX_TRIES=3, LOCK_CYCLES=4).
// Each step drives one cycle of stimulus, pushes the expected post-edge
// outputs to a scoreboard queue and pops/compares them after the edge.
// Define AUTH_DIFF_EN to also check diff_bits.
module tb_code_auth_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       set_valid = 1'b0;
   logic [7:0] set_code = 8'h00;
   logic       guess_valid = 1'b0;
   logic [7:0] guess_code = 8'h00;
   logic       matched, unmatched, rejected, locked, armed;
   logic [1:0] tries_left;
`ifdef AUTH_DIFF_EN
   logic [7:0] diff_bits;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      string      tag;
      logic       m;
      logic       u;
      logic       r;
      logic       l;
      logic       a;
      logic [1:0] t;
      logic [7:0] d;
   } exp_t;

   exp_t sb[$];

   code_auth_fsm #(
      .WIDTH       (8),
      .MAX_TRIES   (3),
      .LOCK_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .set_valid   (set_valid),
      .set_code    (set_code),
      .guess_valid (guess_valid),
      .guess_code  (guess_code),
      .matched     (matched),
      .unmatched   (unmatched),
      .rejected    (rejected),
      .locked      (locked),
      .armed       (armed),
`ifdef AUTH_DIFF_EN
      .diff_bits   (diff_bits),
`endif
      .tries_left  (tries_left)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input string field,
                      input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
      end
   endtask

   task automatic step(input string tag, input logic r_in,
                       input logic sv, input logic [7:0] sc,
                       input logic gv, input logic [7:0] gc,
                       input logic em, input logic eu, input logic er,
                       input logic el, input logic ea,
                       input logic [1:0] et, input logic [7:0] ed);
      exp_t e;
      @(negedge clk);
      rst         = r_in;
      set_valid   = sv;
      set_code    = sc;
      guess_valid = gv;
      guess_code  = gc;
      e.tag = tag; e.m = em; e.u = eu; e.r = er; e.l = el; e.a = ea;
      e.t = et; e.d = ed;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      $display("step %-12s m=%b u=%b r=%b l=%b a=%b t=%0d", e.tag,
               matched, unmatched, rejected, locked, armed, tries_left);
      chk(e.tag, "matched",   {7'd0, matched},   {7'd0, e.m});
      chk(e.tag, "unmatched", {7'd0, unmatched}, {7'd0, e.u});
      chk(e.tag, "rejected",  {7'd0, rejected},  {7'd0, e.r});
      chk(e.tag, "locked",    {7'd0, locked},    {7'd0, e.l});
      chk(e.tag, "armed",     {7'd0, armed},     {7'd0, e.a});
      chk(e.tag, "tries",     {6'd0, tries_left}, {6'd0, e.t});
`ifdef AUTH_DIFF_EN
      chk(e.tag, "diff", diff_bits, e.d);
`endif
   endtask

   initial begin
      //   tag            rst sv sc     gv gc     m  u  r  l  a  t  diff
      step("reset",        1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 3, 8'h00);
      step("idle_guess",   0, 0, 8'h00, 1, 8'hA5, 0, 0, 1, 0, 0, 3, 8'h00);
      step("idle_quiet",   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 3, 8'h00);
      step("set_3c",       0, 1, 8'h3C, 0, 8'h00, 0, 0, 0, 0, 1, 3, 8'h00);
      step("guess_ok",     0, 0, 8'h00, 1, 8'h3C, 1, 0, 0, 0, 1, 3, 8'h00);
      step("guess_3d",     0, 0, 8'h00, 1, 8'h3D, 0, 1, 0, 0, 1, 2, 8'h01);
      step("guess_00",     0, 0, 8'h00, 1, 8'h00, 0, 1, 0, 0, 1, 1, 8'h3C);
      step("guess_reok",   0, 0, 8'h00, 1, 8'h3C, 1, 0, 0, 0, 1, 3, 8'h00);
      step("bad1",         0, 0, 8'h00, 1, 8'h01, 0, 1, 0, 0, 1, 2, 8'h3D);
      step("bad2",         0, 0, 8'h00, 1, 8'h02, 0, 1, 0, 0, 1, 1, 8'h3E);
      step("bad3_lock",    0, 0, 8'h00, 1, 8'h03, 0, 1, 0, 1, 0, 0, 8'h3F);
      step("lock_guess",   0, 0, 8'h00, 1, 8'h3C, 0, 0, 1, 1, 0, 0, 8'h3F);
      step("lock_set",     0, 1, 8'hFF, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h3F);
      step("lock_wait",    0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'h3F);
      step("unlock",       0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 3, 8'h3F);
      step("secret_kept",  0, 0, 8'h00, 1, 8'h3C, 1, 0, 0, 0, 1, 3, 8'h00);
      step("set_and_gs",   0, 1, 8'hFF, 1, 8'hFF, 0, 0, 1, 0, 1, 3, 8'h00);
      step("guess_ff",     0, 0, 8'h00, 1, 8'hFF, 1, 0, 0, 0, 1, 3, 8'h00);
      step("guess_0f",     0, 0, 8'h00, 1, 8'h0F, 0, 1, 0, 0, 1, 2, 8'hF0);
      step("bad_00",       0, 0, 8'h00, 1, 8'h00, 0, 1, 0, 0, 1, 1, 8'hFF);
      step("bad_01_lock",  0, 0, 8'h00, 1, 8'h01, 0, 1, 0, 1, 0, 0, 8'hFE);
      step("lock_cnt2",    0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 0, 8'hFE);
      step("rst_in_lock",  1, 0, 8'h00, 1, 8'hFF, 0, 0, 0, 0, 0, 3, 8'h00);
      step("post_rst_gs",  0, 0, 8'h00, 1, 8'hFF, 0, 0, 1, 0, 0, 3, 8'h00);
      step("post_rst_q",   0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 3, 8'h00);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_code_auth_fsm
